conv2d_engine: RTL and testbench
================================

CONV2D_ENGINE -- requirements
Module: conv2d_engine

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result word width.
REQ-002 SHALL have parameter ADDR_W, default 32, memory address width.
REQ-003 SHALL have parameter ACC_W, default 2*DATA_W+8, accumulator width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port enable  input  1  level start request.
REQ-007 SHALL have port base_addr  input  ADDR_W  job descriptor base, sampled at start.
REQ-008 SHALL have port mem_opdone  input  1  memory completion strobe for the current request.
REQ-009 SHALL have port data_i  input  DATA_W  read data, valid with mem_opdone.
REQ-010 SHALL have port data_o  output  DATA_W  write data.
REQ-011 SHALL have port addr_o  output  ADDR_W  request address.
REQ-012 SHALL have port mem_operation  output  2  00 none, 01 read, 11 write.
REQ-013 SHALL have port done  output  1  job finished.
REQ-014 SHALL have port error  output  1  job rejected; valid while done=1.

Function
REQ-015 SHALL read six descriptor words at base_addr+0..5: width_a, height_a, width_f, height_f, stride, flags (bit0 signed, bit1 ReLU, bit2 saturate).
REQ-016 SHALL place matrix A at base+6, filter F at A_base+height_a*width_a, result R at F_base+height_f*width_f.
REQ-017 SHALL compute out_h=(height_a-height_f)/stride+1 and out_w=(width_a-width_f)/stride+1 (integer division, stride restricted to 1..4).
REQ-018 SHALL compute R[i][j]=sum over k<height_f, l<width_f of A[i*stride+k][j*stride+l]*F[k][l], written to R_base+i*out_w+j.
REQ-019 SHALL treat operands as two's complement when flags.bit0=1, otherwise unsigned; products sign/zero extended to ACC_W.
REQ-020 SHALL, with flags.bit1=1, replace negative sums by 0 before output.
REQ-021 SHALL, with flags.bit2=1, clamp the sum to the DATA_W range (signed or unsigned per bit0), otherwise truncate to the low DATA_W bits.
REQ-022 SHALL hold mem_operation/addr_o/data_o stable from request issue until the cycle mem_opdone=1, then drop mem_operation to 00 for at least one cycle before the next request.
REQ-023 SHALL ignore mem_opdone while mem_operation=00.
REQ-024 SHALL use states IDLE, FETCH_DESC, CHECK, LOAD_A, LOAD_F, MAC, WRITE, NEXT, DONE.
REQ-025 SHALL move IDLE->FETCH_DESC on enable=1; FETCH_DESC->CHECK after the sixth word; CHECK->LOAD_A if valid else DONE with error=1.
REQ-026 SHALL flag invalid when width_f=0, height_f=0, width_f>width_a, height_f>height_a, or stride outside 1..4; no reads of A/F and no writes then occur.
REQ-027 SHALL cycle LOAD_A->LOAD_F->MAC per tap, MAC->WRITE after the last tap, WRITE->NEXT on mem_opdone, NEXT clears the accumulator and advances j then i, NEXT->DONE after the last output.
REQ-028 SHALL assert done in DONE and hold it until enable=0, then return to IDLE with done=0 and error=0 the next cycle.
REQ-029 SHALL take exactly one cycle per MAC state; total cycles for a tap equal two memory latencies plus 5.
REQ-030 SHALL stay in DONE when enable remains high (no auto-restart).

Reset
REQ-031 SHALL, on reset, force state IDLE, done=0, error=0, mem_operation=00, addr_o=0, data_o=0, accumulator and loop counters 0.
REQ-032 SHALL abandon any outstanding request when reset asserts mid-job; a later mem_opdone is ignored.

Structure
REQ-033 SHALL take mem operation encodings, descriptor offsets, flag bit positions and the state enum from shared package conv_pkg.
REQ-034 SHALL instantiate one sub-module conv_mac (multiply, extend, accumulate, ReLU, saturate) parametrised by DATA_W and ACC_W.

Verification
REQ-035 SHALL cover 4x4 A=1..16, 2x2 F={1,0,0,1}, stride 1, unsigned -> nine writes of 7,9,11,15,17,19,23,25,27 at R_base..R_base+8, done=1, error=0.
REQ-036 SHALL cover same A and F with stride 2 -> four writes of 7,11,23,27.
REQ-037 SHALL cover signed A all -3, 2x2 F all 1, ReLU on -> every result 0; ReLU off -> every result -12.
REQ-038 SHALL cover DATA_W=8, saturate on, unsigned 1x1 A=200, F=2 -> result 255; saturate off -> 144.
REQ-039 SHALL cover width_f=5 with width_a=4 -> done=1, error=1, no A/F reads and no writes.
REQ-040 SHALL cover reset asserted during LOAD_F with mem_opdone arriving afterwards -> IDLE, mem_operation=00, no write issued.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared constants and state encoding for the conv2d engine.
// Holds the memory op codes, descriptor word offsets, flag bit positions and FSM states.
package conv_pkg;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b11;

  localparam logic [2:0] OFF_WA     = 3'd0;
  localparam logic [2:0] OFF_HA     = 3'd1;
  localparam logic [2:0] OFF_WF     = 3'd2;
  localparam logic [2:0] OFF_HF     = 3'd3;
  localparam logic [2:0] OFF_STRIDE = 3'd4;
  localparam logic [2:0] OFF_FLAGS  = 3'd5;
  localparam int         DESC_WORDS = 6;

  localparam int FLAG_SIGNED = 0;
  localparam int FLAG_RELU   = 1;
  localparam int FLAG_SAT    = 2;

  typedef enum logic [3:0] {
    IDLE,
    FETCH_DESC,
    CHECK,
    LOAD_A,
    LOAD_F,
    MAC,
    WRITE,
    NEXT,
    DONE
  } state_e;

endpackage

// File: rtl/conv_mac.sv
// Multiply-accumulate unit: extends operands, accumulates, then applies ReLU and clamp/truncate.
// Ports: clk, reset, clr, en, is_signed, relu, sat, a, f -> result (DATA_W, from current accumulator).
module conv_mac #(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 2*DATA_W+8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  input  logic              is_signed,
  input  logic              relu,
  input  logic              sat,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] result
);

  localparam logic [ACC_W-1:0] SMAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = ~SMAX;
  localparam logic [ACC_W-1:0] UMAX =
    {{(ACC_W-DATA_W){1'b0}}, {DATA_W{1'b1}}};

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] a_ext, f_ext, prod, sum_r;

  always_comb begin
    a_ext = {{(ACC_W-DATA_W){is_signed & a[DATA_W-1]}}, a};
    f_ext = {{(ACC_W-DATA_W){is_signed & f[DATA_W-1]}}, f};
    // low ACC_W bits of the product are right for both signednesses
    prod  = a_ext * f_ext;
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (en)
      acc_d = acc_q + prod;
  end

  always_comb begin
    sum_r = acc_q;
    if (relu && is_signed && acc_q[ACC_W-1])
      sum_r = '0;
    result = sum_r[DATA_W-1:0];
    if (sat) begin
      if (is_signed) begin
        if ($signed(sum_r) > $signed(SMAX))
          result = SMAX[DATA_W-1:0];
        else if ($signed(sum_r) < $signed(SMIN))
          result = SMIN[DATA_W-1:0];
      end else if (sum_r > UMAX) begin
        result = UMAX[DATA_W-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      acc_q <= '0;
    else
      acc_q <= acc_d;
  end

endmodule

// File: rtl/conv2d_engine.sv
// Descriptor-driven 2D convolution engine over a single request/opdone memory port.
// Ports: clk, reset, enable, base_addr, mem_opdone, data_i -> data_o, addr_o, mem_operation, done, error.
module conv2d_engine
  import conv_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int ACC_W  = 2*DATA_W+8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_opdone,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [1:0]        mem_operation,
  output logic              done,
  output logic              error
);

  state_e            state_q, state_d;
  logic [1:0]        mem_op_q, mem_op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] wa_q, wa_d, ha_q, ha_d;
  logic [DATA_W-1:0] wf_q, wf_d, hf_q, hf_d;
  logic [DATA_W-1:0] stride_q, stride_d;
  logic [2:0]        flags_q, flags_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] f_base_q, f_base_d;
  logic [ADDR_W-1:0] r_base_q, r_base_d;
  logic [DATA_W-1:0] out_h_q, out_h_d, out_w_q, out_w_d;
  logic [DATA_W-1:0] i_q, i_d, j_q, j_d, k_q, k_d, l_q, l_d;
  logic [DATA_W-1:0] a_val_q, a_val_d, f_val_q, f_val_d;

  logic              mac_en, mac_clr;
  logic [DATA_W-1:0] mac_res;
  logic [DATA_W-1:0] row, col;
  logic [ADDR_W-1:0] a_addr, f_addr, r_addr;
  logic              invalid, last_tap, last_out;

  function automatic logic [DATA_W-1:0] div_stride(
    input logic [DATA_W-1:0] d,
    input logic [2:0]        s
  );
    case (s)
      3'd2:    return d >> 1;
      3'd3:    return d / DATA_W'(3);
      3'd4:    return d >> 2;
      default: return d;
    endcase
  endfunction

  conv_mac #(
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .reset    (reset),
    .clr      (mac_clr),
    .en       (mac_en),
    .is_signed(flags_q[FLAG_SIGNED]),
    .relu     (flags_q[FLAG_RELU]),
    .sat      (flags_q[FLAG_SAT]),
    .a        (a_val_q),
    .f        (f_val_q),
    .result   (mac_res)
  );

  always_comb begin
    row = i_q * stride_q + k_q;
    col = j_q * stride_q + l_q;
    a_addr = a_base_q + ADDR_W'(row) * ADDR_W'(wa_q)
           + ADDR_W'(col);
    f_addr = f_base_q + ADDR_W'(k_q) * ADDR_W'(wf_q)
           + ADDR_W'(l_q);
    r_addr = r_base_q + ADDR_W'(i_q) * ADDR_W'(out_w_q)
           + ADDR_W'(j_q);
    invalid = (wf_q == '0) || (hf_q == '0) ||
              (wf_q > wa_q) || (hf_q > ha_q) ||
              (stride_q == '0) ||
              (stride_q > DATA_W'(4));
    last_tap = (l_q == wf_q - DATA_W'(1)) &&
               (k_q == hf_q - DATA_W'(1));
    last_out = (j_q == out_w_q - DATA_W'(1)) &&
               (i_q == out_h_q - DATA_W'(1));
  end

  always_comb begin
    state_d  = state_q;
    mem_op_d = mem_op_q;
    addr_d   = addr_q;
    data_d   = data_q;
    done_d   = done_q;
    error_d  = error_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    wa_d     = wa_q;
    ha_d     = ha_q;
    wf_d     = wf_q;
    hf_d     = hf_q;
    stride_d = stride_q;
    flags_d  = flags_q;
    a_base_d = a_base_q;
    f_base_d = f_base_q;
    r_base_d = r_base_q;
    out_h_d  = out_h_q;
    out_w_d  = out_w_q;
    i_d      = i_q;
    j_d      = j_q;
    k_d      = k_q;
    l_d      = l_q;
    a_val_d  = a_val_q;
    f_val_d  = f_val_q;
    mac_en   = 1'b0;
    mac_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        mac_clr = 1'b1;
        if (enable) begin
          base_d  = base_addr;
          cnt_d   = '0;
          error_d = 1'b0;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          l_d     = '0;
          state_d = FETCH_DESC;
        end
      end
      FETCH_DESC: begin
        if (mem_op_q == MEM_NONE) begin
          mem_op_d = MEM_READ;
          addr_d   = base_q + ADDR_W'(cnt_q);
        end else if (mem_opdone) begin
          mem_op_d = MEM_NONE;
          case (cnt_q)
            OFF_WA:     wa_d     = data_i;
            OFF_HA:     ha_d     = data_i;
            OFF_WF:     wf_d     = data_i;
            OFF_HF:     hf_d     = data_i;
            OFF_STRIDE: stride_d = data_i;
            default:    flags_d  = data_i[2:0];
          endcase
          if (cnt_q == OFF_FLAGS)
            state_d = CHECK;
          else
            cnt_d = cnt_q + 3'd1;
        end
      end
      CHECK: begin
        a_base_d = base_q + ADDR_W'(DESC_WORDS);
        f_base_d = a_base_d
                 + ADDR_W'(ha_q) * ADDR_W'(wa_q);
        r_base_d = f_base_d
                 + ADDR_W'(hf_q) * ADDR_W'(wf_q);
        out_h_d = div_stride(ha_q - hf_q, stride_q[2:0])
                + DATA_W'(1);
        out_w_d = div_stride(wa_q - wf_q, stride_q[2:0])
                + DATA_W'(1);
        if (invalid) begin
          error_d = 1'b1;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          state_d = LOAD_A;
        end
      end
      LOAD_A: begin
        if (mem_op_q == MEM_NONE) begin
          mem_op_d = MEM_READ;
          addr_d   = a_addr;
        end else if (mem_opdone) begin
          mem_op_d = MEM_NONE;
          a_val_d  = data_i;
          state_d  = LOAD_F;
        end
      end
      LOAD_F: begin
        if (mem_op_q == MEM_NONE) begin
          mem_op_d = MEM_READ;
          addr_d   = f_addr;
        end else if (mem_opdone) begin
          mem_op_d = MEM_NONE;
          f_val_d  = data_i;
          state_d  = MAC;
        end
      end
      MAC: begin
        mac_en = 1'b1;
        if (last_tap) begin
          k_d     = '0;
          l_d     = '0;
          state_d = WRITE;
        end else begin
          if (l_q == wf_q - DATA_W'(1)) begin
            l_d = '0;
            k_d = k_q + DATA_W'(1);
          end else begin
            l_d = l_q + DATA_W'(1);
          end
          state_d = LOAD_A;
        end
      end
      WRITE: begin
        if (mem_op_q == MEM_NONE) begin
          mem_op_d = MEM_WRITE;
          addr_d   = r_addr;
          data_d   = mac_res;
        end else if (mem_opdone) begin
          mem_op_d = MEM_NONE;
          state_d  = NEXT;
        end
      end
      NEXT: begin
        mac_clr = 1'b1;
        if (last_out) begin
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          if (j_q == out_w_q - DATA_W'(1)) begin
            j_d = '0;
            i_d = i_q + DATA_W'(1);
          end else begin
            j_d = j_q + DATA_W'(1);
          end
          state_d = LOAD_A;
        end
      end
      DONE: begin
        if (!enable) begin
          done_d  = 1'b0;
          error_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mem_op_q <= MEM_NONE;
      addr_q   <= '0;
      data_q   <= '0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      base_q   <= '0;
      cnt_q    <= '0;
      wa_q     <= '0;
      ha_q     <= '0;
      wf_q     <= '0;
      hf_q     <= '0;
      stride_q <= '0;
      flags_q  <= '0;
      a_base_q <= '0;
      f_base_q <= '0;
      r_base_q <= '0;
      out_h_q  <= '0;
      out_w_q  <= '0;
      i_q      <= '0;
      j_q      <= '0;
      k_q      <= '0;
      l_q      <= '0;
      a_val_q  <= '0;
      f_val_q  <= '0;
    end else begin
      state_q  <= state_d;
      mem_op_q <= mem_op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      done_q   <= done_d;
      error_q  <= error_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      wa_q     <= wa_d;
      ha_q     <= ha_d;
      wf_q     <= wf_d;
      hf_q     <= hf_d;
      stride_q <= stride_d;
      flags_q  <= flags_d;
      a_base_q <= a_base_d;
      f_base_q <= f_base_d;
      r_base_q <= r_base_d;
      out_h_q  <= out_h_d;
      out_w_q  <= out_w_d;
      i_q      <= i_d;
      j_q      <= j_d;
      k_q      <= k_d;
      l_q      <= l_d;
      a_val_q  <= a_val_d;
      f_val_q  <= f_val_d;
    end
  end

  assign mem_operation = mem_op_q;
  assign addr_o        = addr_q;
  assign data_o        = data_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_conv2d_engine.sv
// Bench for conv2d_engine: memory responder with variable latency plus a write scoreboard.
// Ports: none (drives every DUT port, DATA_W=8).
module tb_conv2d_engine;

  localparam int DW = 8;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          mem_opdone = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic [DW-1:0] data_o;
  logic [AW-1:0] addr_o;
  logic [1:0]    mem_operation;
  logic          done;
  logic          error;

  conv2d_engine #(
    .DATA_W(DW),
    .ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .base_addr    (base_addr),
    .mem_opdone   (mem_opdone),
    .data_i       (data_i),
    .data_o       (data_o),
    .addr_o       (addr_o),
    .mem_operation(mem_operation),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint addr;
    longint data;
  } wr_t;

  int      n_chk = 0;
  int      n_pass = 0;
  logic [DW-1:0] mem [int];
  wr_t     exp_q[$];
  wr_t     e_wr;
  int      lat = 1;
  int      wait_cnt = 0;
  int      n_wr = 0;
  int      n_rd_af = 0;
  longint  af_lo = 0;
  bit      stray = 0;
  int      qa[$];
  int      qf[$];

  task automatic check(string tag, longint got, longint exp);
    n_chk++;
    if (got == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // memory responder: opdone after lat extra cycles of a held request
  initial begin
    forever begin
      @(negedge clk);
      mem_opdone = 1'b0;
      if (stray) begin
        mem_opdone = 1'b1;
        stray = 0;
      end else if (mem_operation == 2'b00) begin
        wait_cnt = 0;
      end else if (wait_cnt < lat) begin
        wait_cnt++;
      end else begin
        wait_cnt = 0;
        mem_opdone = 1'b1;
        if (mem_operation == 2'b01) begin
          data_i = mem.exists(int'(addr_o)) ?
                   mem[int'(addr_o)] : '0;
          if (longint'(addr_o) >= af_lo)
            n_rd_af++;
        end else begin
          n_wr++;
          mem[int'(addr_o)] = data_o;
          if (exp_q.size() == 0) begin
            check("unexpected_write", longint'(addr_o), -1);
          end else begin
            e_wr = exp_q.pop_front();
            check("wr_addr", longint'(addr_o), e_wr.addr);
            check("wr_data", longint'(data_o), e_wr.data);
          end
        end
      end
    end
  end

  function automatic longint ext(int v, bit sg);
    longint r;
    r = longint'(v & 255);
    if (sg && r > 127)
      r -= 256;
    return r;
  endfunction

  task automatic load_job(int base, int wa, int ha, int wf,
                          int hf, int st, int fl, bit push);
    int ab, fb, rb, oh, ow;
    longint s;
    bit sg;
    mem[base+0] = DW'(wa);
    mem[base+1] = DW'(ha);
    mem[base+2] = DW'(wf);
    mem[base+3] = DW'(hf);
    mem[base+4] = DW'(st);
    mem[base+5] = DW'(fl);
    ab = base + 6;
    fb = ab + wa * ha;
    rb = fb + wf * hf;
    af_lo = ab;
    foreach (qa[n]) mem[ab+n] = DW'(qa[n]);
    foreach (qf[n]) mem[fb+n] = DW'(qf[n]);
    if (push) begin
      sg = fl[0];
      oh = (ha - hf) / st + 1;
      ow = (wa - wf) / st + 1;
      for (int i = 0; i < oh; i++)
        for (int j = 0; j < ow; j++) begin
          s = 0;
          for (int k = 0; k < hf; k++)
            for (int l = 0; l < wf; l++)
              s += ext(qa[(i*st+k)*wa + j*st+l], sg) *
                   ext(qf[k*wf+l], sg);
          if (fl[1] && s < 0) s = 0;
          if (fl[2]) begin
            if (sg) begin
              if (s > 127) s = 127;
              if (s < -128) s = -128;
            end else if (s > 255) begin
              s = 255;
            end
          end
          exp_q.push_back('{longint'(rb + i*ow + j), s & 255});
        end
    end
  endtask

  task automatic run_job(string tag, int base, bit exp_err);
    int cyc = 0;
    base_addr = AW'(base);
    enable = 1'b1;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_error"}, error, exp_err);
    check({tag, "_pending"}, exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    check({tag, "_hold"}, done, 1);
    check({tag, "_norestart"}, mem_operation, 0);
    enable = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check({tag, "_done_clr"}, done, 0);
    check({tag, "_err_clr"}, error, 0);
  endtask

  initial begin
    int wr0, rd0, cyc;
    longint fb;
    repeat (3) @(negedge clk);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_op", mem_operation, 0);
    check("rst_addr", addr_o, 0);
    check("rst_data", data_o, 0);
    reset = 1'b0;
    @(negedge clk);

    qa = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    qf = {1, 0, 0, 1};
    lat = 1;
    load_job(100, 4, 4, 2, 2, 1, 0, 1);
    run_job("s1", 100, 0);

    lat = 0;
    load_job(200, 4, 4, 2, 2, 2, 0, 1);
    run_job("s2", 200, 0);

    qa.delete();
    for (int n = 0; n < 9; n++) qa.push_back(-3);
    qf = {1, 1, 1, 1};
    lat = 2;
    load_job(300, 3, 3, 2, 2, 1, 3, 1);
    run_job("relu_on", 300, 0);
    lat = 1;
    load_job(400, 3, 3, 2, 2, 1, 1, 1);
    run_job("relu_off", 400, 0);

    qa = {200};
    qf = {2};
    load_job(500, 1, 1, 1, 1, 1, 4, 1);
    run_job("sat_on", 500, 0);
    load_job(600, 1, 1, 1, 1, 1, 0, 1);
    run_job("sat_off", 600, 0);

    qa = {1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
    qf = {1, 1, 1, 1, 1};
    wr0 = n_wr;
    rd0 = n_rd_af;
    load_job(700, 4, 4, 5, 1, 1, 0, 0);
    run_job("bad_wf", 700, 1);
    check("bad_wf_writes", n_wr - wr0, 0);
    check("bad_wf_af_reads", n_rd_af - rd0, 0);

    qf = {1, 0, 0, 1};
    lat = 3;
    wr0 = n_wr;
    load_job(800, 4, 4, 2, 2, 1, 0, 0);
    fb = 800 + 6 + 16;
    base_addr = AW'(800);
    enable = 1'b1;
    cyc = 0;
    while (!(mem_operation == 2'b01 &&
             longint'(addr_o) >= fb) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_reached_f", cyc < 2000, 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    enable = 1'b0;
    stray = 1;
    repeat (6) @(negedge clk);
    check("rst_mid_op", mem_operation, 0);
    check("rst_mid_done", done, 0);
    check("rst_mid_error", error, 0);
    check("rst_mid_addr", addr_o, 0);
    check("rst_mid_writes", n_wr - wr0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
